// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int LINES_DEF = 16;
    localparam int WORDS_DEF = 4;

    localparam int OFF_W  = 2;
    localparam int WORD_W = $clog2(WORDS_DEF);
    localparam int IDX_W  = $clog2(LINES_DEF);
    localparam int TAG_W  = 32 - OFF_W - WORD_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous word and tag writes,
// single-cycle clear of all valid bits. Only the valid bits are reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int TW    = TAG_W,
    parameter int IW    = IDX_W,
    parameter int WW    = WORD_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [IW-1:0] rd_index_i,
    input  logic [WW-1:0] rd_word_i,
    output logic          rd_valid_o,
    output logic [TW-1:0] rd_tag_o,
    output logic [31:0]   rd_data_o,
    input  logic [IW-1:0] wr_index_i,
    input  logic [WW-1:0] wr_word_i,
    input  logic          wr_en_i,
    input  logic [31:0]   wr_data_i,
    input  logic          tag_we_i,
    input  logic [TW-1:0] wr_tag_i,
    input  logic          clr_all_i
);

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

    // Clear-all wins over a same-cycle tag write so a pending invalidate
    // also kills the line that is just completing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with line-fill FSM.
// Define ICACHE_PERF_EN to add the hit_count/miss_count performance counters.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        inv,
    output logic [31:0] instrF,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    // Package widths describe the default geometry; overrides recompute.
    localparam int WW = (WORDS == WORDS_DEF) ? WORD_W : $clog2(WORDS);
    localparam int IW = (LINES == LINES_DEF) ? IDX_W  : $clog2(LINES);
    localparam int TW = 32 - OFF_W - WW - IW;
    localparam logic [WW-1:0] LAST_BEAT = WW'(WORDS - 1);

    logic [WW-1:0] pc_word;
    logic [IW-1:0] pc_index;
    logic [TW-1:0] pc_tag;
    logic          unused_pc_off;

    assign pc_word       = pcF[OFF_W +: WW];
    assign pc_index      = pcF[OFF_W + WW +: IW];
    assign pc_tag        = pcF[31 -: TW];
    assign unused_pc_off = ^pcF[OFF_W-1:0];

    state_e           state_q;
    logic [TW+IW-1:0] miss_addr_q;
    logic [WW-1:0]    beat_cnt_q;
    logic             inv_pend_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;

    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    logic          hit;
    logic          fill_beat;
    logic          last_beat;
    logic          clr_all;

    assign hit       = rd_valid && (rd_tag == pc_tag);
    assign fill_beat = (state_q == FILL) && mem_rvalid;
    assign last_beat = fill_beat && (beat_cnt_q == LAST_BEAT);
    assign clr_all   = ((state_q == IDLE) && inv) || (last_beat && (inv_pend_q || inv));

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TW    (TW),
        .IW    (IW),
        .WW    (WW)
    ) u_array (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rd_index_i (pc_index),
        .rd_word_i  (pc_word),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (instrF),
        .wr_index_i (miss_addr_q[IW-1:0]),
        .wr_word_i  (beat_cnt_q),
        .wr_en_i    (fill_beat),
        .wr_data_i  (mem_rdata),
        .tag_we_i   (last_beat),
        .wr_tag_i   (miss_addr_q[TW+IW-1:IW]),
        .clr_all_i  (clr_all)
    );

    assign stall    = (state_q != IDLE) || !hit;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            beat_cnt_q  <= '0;
            inv_pend_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        miss_addr_q <= {pc_tag, pc_index};
                        beat_cnt_q  <= '0;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= {pc_tag, pc_index, {(WW + OFF_W){1'b0}}};
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == LAST_BEAT) begin
                            inv_pend_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch-stage PC register and slow main memory. Looks up `pcF` combinationally and returns `instrF` in the same cycle on a hit. On a miss it asserts `stall` to the hazard logic, which ORs it into `stallF`/`stallD`. It then fetches the whole line with a request/grant plus beat handshake and resumes the fetch.

## Interface
Parameters:
- `LINES`, 16: number of lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 resets the block.
- `pcF`  in  32  fetch address; bits [1:0] ignored.
- `inv`  in  1  invalidate-all pulse.
- `instrF`  out  32  instruction word; valid when `stall`=0.
- `stall`  out  1  miss in progress or pending.
- `mem_req`  out  1  line-fill request.
- `mem_addr`  out  32  line-aligned fill address.
- `mem_gnt`  in  1  memory accepts the request.
- `mem_rvalid`  in  1  one data beat is valid.
- `mem_rdata`  in  32  beat data.
- `hit_count`, `miss_count`  out  32 each  present only with `ICACHE_PERF_EN`.

## Operation
- Address split: offset = [1:0]; word = next log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining upper bits. Defaults: word [3:2], index [7:4], tag [31:8].
- Storage per line: a valid bit, a tag, and WORDS data words.
- FSM states are IDLE, REQ and FILL.
- IDLE:
  - hit = valid[index] && tag match.
  - `instrF` = data[index][word]; `stall` = !hit, combinational.
  - On a miss: latch `{tag, index}` into `miss_addr`, clear `beat_cnt`, go to REQ.
- REQ:
  - `mem_req`=1; `mem_addr` = `{miss_addr, zeros}`.
  - Stays in REQ until `mem_gnt`=1 is sampled, then goes to FILL.
- FILL:
  - `mem_req`=0.
  - Each `mem_rvalid` writes `mem_rdata` into data[miss_index][beat_cnt] and increments `beat_cnt`.
  - Beats may be non-consecutive.
  - The last beat (`beat_cnt`=WORDS-1) also writes the tag, sets valid, and returns to IDLE.
- `stall` is 1 in REQ and FILL.
- In all states other than IDLE, `instrF` is don't-care. The implementation drives data[index][word].
- `mem_rvalid` is ignored in IDLE and REQ. `mem_gnt` is ignored outside REQ.
- `pcF` is held stable by the pipeline while `stall`=1. The fill always targets the latched `miss_addr`, even if `pcF` changes.
- `inv`:
  - In IDLE, clears all valid bits at the edge; `stall` follows the post-clear lookup from the next cycle.
  - In REQ or FILL, `inv` sets `inv_pend`. On fill completion, all valids are cleared, including the new line, and `inv_pend` clears.
  - `inv` in the same cycle as the last beat is treated as pending.

## Timing
- Hit: 0-cycle latency; `stall`=0.
- Miss with zero-wait memory (`mem_gnt` in the first REQ cycle, beats back-to-back):
  - c0: IDLE, miss.
  - c1: REQ, granted.
  - c2 to c1+WORDS: beats.
  - Next cycle: IDLE, hit.
  - `stall` is high for WORDS+2 cycles (6 at default).
- Each extra grant wait or beat gap adds exactly one stall cycle.
- Reset, while `rst`=0 and asynchronously:
  - state=IDLE, all valids=0, `beat_cnt`=0, `inv_pend`=0.
  - `mem_req`=0, `mem_addr`=0, counters=0.
  - `stall` then equals the miss result for `pcF` (1 with all lines invalid).
- Reset in the middle of REQ or FILL abandons the fill. Partially written words stay invalid.
- Memory beats still arriving after reset are ignored because the FSM is back in IDLE.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_count` increments on every IDLE cycle with a hit.
  - `miss_count` increments on every IDLE→REQ transition.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by reset only.
- `ICACHE_PERF_EN` undefined: no counter ports and no counter logic.

## Structure
- Package `icache_pkg` holds:
  - the state enum (IDLE, REQ, FILL);
  - default `LINES`/`WORDS`;
  - localparams for the offset, word, index and tag widths, derived via $clog2.
- Sub-module `icache_array` holds valid, tag and data storage:
  - asynchronous read;
  - synchronous word write;
  - tag/valid write;
  - valid-clear-all;
  - async active-low reset of the valid bits only.
- FSM, counters and the handshake live in the top level.

## Test plan
- Cold miss: after reset, `pcF`=0x00400000; memory grants immediately and returns 0x20080005, 0x20090007, 0x01095020, 0xAC0A0000 back-to-back. Required: `mem_addr`=0x00400000, `stall` high 6 cycles, then `instrF`=0x20080005 with `stall`=0.
- Hit sweep: after the fill, `pcF` = 0x00400004, 0x00400008, 0x0040000C. Required: `instrF` = the matching beat each cycle with `stall`=0 and no `mem_req`.
- Conflict miss: `pcF`=0x00400100 (same index, new tag), with a 3-cycle grant delay and a 1-cycle gap between beats 1 and 2. Required: `stall` high 10 cycles; the line is replaced, and 0x00400000 misses again afterwards.
- Invalidate: `inv` pulse in IDLE, then an idle-cycle `inv` during FILL. Required: the next lookup of 0x00400000 misses, and the line just filled is invalid on completion.
- Reset mid-FILL: `rst`=0 after 2 beats. Required: `mem_req`=0 and state IDLE immediately; after reset, that address misses with a full refill.
- Perf (`ICACHE_PERF_EN` defined): scenarios 1–2 give `miss_count`=1 and `hit_count`=4.
